// File: rtl/alu_share_arbiter_if.sv
// Request, response and ALU-side signal bundle for the two-requester ALU sharer.
// Latency: none; this is wiring only. The arbiter owns all sequencing.
// Backpressure: valid/ready on request and response sides; the ALU side has none.
interface alu_share_arbiter_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
);
   // Requester 0 request channel
   logic            req0_valid;
   logic            req0_ready;
   logic [2:0]      req0_funct3;
   logic [6:0]      req0_funct7;
   logic [XLEN-1:0] req0_rs1;
   logic [XLEN-1:0] req0_rs2;
   // Requester 1 request channel
   logic            req1_valid;
   logic            req1_ready;
   logic [2:0]      req1_funct3;
   logic [6:0]      req1_funct7;
   logic [XLEN-1:0] req1_rs1;
   logic [XLEN-1:0] req1_rs2;
   // Response channels; resp_data is shared and qualified by either valid
   logic            resp0_valid;
   logic            resp0_ready;
   logic            resp1_valid;
   logic            resp1_ready;
   logic [XLEN-1:0] resp_data;
   // Shared combinational ALU
   logic [2:0]      alu_funct3;
   logic [6:0]      alu_funct7;
   logic [XLEN-1:0] alu_rs1;
   logic [XLEN-1:0] alu_rs2;
   logic [XLEN-1:0] alu_rd;
   // Status
   logic            busy;
   logic [CNT_W-1:0] op_count;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_funct3, req0_funct7, req0_rs1, req0_rs2,
      input  req1_valid, req1_funct3, req1_funct7, req1_rs1, req1_rs2,
      input  resp0_ready, resp1_ready, alu_rd,
      output req0_ready, req1_ready,
      output resp0_valid, resp1_valid, resp_data,
      output alu_funct3, alu_funct7, alu_rs1, alu_rs2,
      output busy, op_count
   );

   // Requester / ALU side
   modport master (
      output req0_valid, req0_funct3, req0_funct7, req0_rs1, req0_rs2,
      output req1_valid, req1_funct3, req1_funct7, req1_rs1, req1_rs2,
      output resp0_ready, resp1_ready, alu_rd,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp1_valid, resp_data,
      input  alu_funct3, alu_funct7, alu_rs1, alu_rs2,
      input  busy, op_count
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational RV64 ALU between two requesters with round-robin grant.
// Latency: accept edge, one EXEC cycle, result registered at the next edge; >= 3 cycles per op.
// Backpressure: result and valid held until the owner's resp_ready; no new grant until back in IDLE.
module alu_share_arbiter #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input logic                clk,
   input logic                rst_n,
   alu_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state_q,       state_d;
   logic             prio_q,        prio_d;
   logic             owner_q,       owner_d;
   logic             resp0_valid_q, resp0_valid_d;
   logic             resp1_valid_q, resp1_valid_d;
   logic [XLEN-1:0]  resp_data_q,   resp_data_d;
   logic [2:0]       alu_funct3_q,  alu_funct3_d;
   logic [6:0]       alu_funct7_q,  alu_funct7_d;
   logic [XLEN-1:0]  alu_rs1_q,     alu_rs1_d;
   logic [XLEN-1:0]  alu_rs2_q,     alu_rs2_d;
   logic [CNT_W-1:0] op_count_q,    op_count_d;

   logic gnt0;
   logic gnt1;
   logic owner_rdy;

   // Grant, operand capture and sequencing: pick in IDLE, one EXEC cycle, hold in RESP
   // until the owner takes the result. prio only flips on completion, so a stalled
   // owner keeps the other requester waiting without losing its turn afterwards.
   always_comb begin
      state_d       = state_q;
      prio_d        = prio_q;
      owner_d       = owner_q;
      resp0_valid_d = resp0_valid_q;
      resp1_valid_d = resp1_valid_q;
      resp_data_d   = resp_data_q;
      alu_funct3_d  = alu_funct3_q;
      alu_funct7_d  = alu_funct7_q;
      alu_rs1_d     = alu_rs1_q;
      alu_rs2_d     = alu_rs2_q;
      op_count_d    = op_count_q;
      gnt0          = 1'b0;
      gnt1          = 1'b0;
      owner_rdy     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.req0_valid && (!bus.req1_valid || !prio_q)) begin
               gnt0 = 1'b1;
            end else if (bus.req1_valid) begin
               gnt1 = 1'b1;
            end

            if (gnt0) begin
               alu_funct3_d = bus.req0_funct3;
               alu_funct7_d = bus.req0_funct7;
               alu_rs1_d    = bus.req0_rs1;
               alu_rs2_d    = bus.req0_rs2;
               owner_d      = 1'b0;
               state_d      = S_EXEC;
            end else if (gnt1) begin
               alu_funct3_d = bus.req1_funct3;
               alu_funct7_d = bus.req1_funct7;
               alu_rs1_d    = bus.req1_rs1;
               alu_rs2_d    = bus.req1_rs2;
               owner_d      = 1'b1;
               state_d      = S_EXEC;
            end
         end

         S_EXEC: begin
            // Operands have been stable on the ALU for a full cycle; capture its result.
            resp_data_d = bus.alu_rd;
            if (owner_q) begin
               resp1_valid_d = 1'b1;
            end else begin
               resp0_valid_d = 1'b1;
            end
            state_d = S_RESP;
         end

         S_RESP: begin
            // The non-owner's resp_ready is deliberately not looked at.
            owner_rdy = owner_q ? bus.resp1_ready : bus.resp0_ready;
            if (owner_rdy) begin
               resp0_valid_d = 1'b0;
               resp1_valid_d = 1'b0;
               op_count_d    = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               prio_d        = ~owner_q;
               state_d       = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight op without a response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         prio_q        <= 1'b0;
         owner_q       <= 1'b0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp_data_q   <= '0;
         alu_funct3_q  <= '0;
         alu_funct7_q  <= '0;
         alu_rs1_q     <= '0;
         alu_rs2_q     <= '0;
         op_count_q    <= '0;
      end else begin
         state_q       <= state_d;
         prio_q        <= prio_d;
         owner_q       <= owner_d;
         resp0_valid_q <= resp0_valid_d;
         resp1_valid_q <= resp1_valid_d;
         resp_data_q   <= resp_data_d;
         alu_funct3_q  <= alu_funct3_d;
         alu_funct7_q  <= alu_funct7_d;
         alu_rs1_q     <= alu_rs1_d;
         alu_rs2_q     <= alu_rs2_d;
         op_count_q    <= op_count_d;
      end
   end

   assign bus.req0_ready  = gnt0;
   assign bus.req1_ready  = gnt1;
   assign bus.resp0_valid = resp0_valid_q;
   assign bus.resp1_valid = resp1_valid_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.alu_funct3  = alu_funct3_q;
   assign bus.alu_funct7  = alu_funct7_q;
   assign bus.alu_rs1     = alu_rs1_q;
   assign bus.alu_rs2     = alu_rs2_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.op_count    = op_count_q;

   // At most one grant, and never while an op is in flight.
   a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.req0_ready && bus.req1_ready));
   a_no_grant_busy : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != S_IDLE) |-> !(bus.req0_ready || bus.req1_ready));
   // A stalled response keeps its valid and data.
   a_resp0_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (bus.resp0_valid && !bus.resp0_ready) |=> (bus.resp0_valid && $stable(bus.resp_data)));
   a_resp1_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (bus.resp1_valid && !bus.resp1_ready) |=> (bus.resp1_valid && $stable(bus.resp_data)));
   // Only one response channel is ever active.
   a_one_resp : assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.resp0_valid && bus.resp1_valid));

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational RV64 ALU (funct3/funct7/rs1/rs2 in, rd out) between two requesters.
- Requesters are, for example, the integer pipe and the address/branch unit.
- Round-robin arbitration, valid/ready on both the request and response sides, and registered operands and result.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
XLEN, 64, operand/result width
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_funct3  in  3  requester 0 funct3
req0_funct7  in  7  requester 0 funct7
req0_rs1  in  XLEN  requester 0 operand 1
req0_rs2  in  XLEN  requester 0 operand 2
req1_valid, req1_ready, req1_funct3, req1_funct7, req1_rs1, req1_rs2  (same as requester 0)
resp0_valid  out  1  result for requester 0 available
resp0_ready  in  1  requester 0 takes result
resp1_valid  out  1  result for requester 1 available
resp1_ready  in  1  requester 1 takes result
resp_data  out  XLEN  result, valid while either resp valid is high
alu_funct3  out  3  to ALU
alu_funct7  out  7  to ALU
alu_rs1  out  XLEN  to ALU
alu_rs2  out  XLEN  to ALU
alu_rd  in  XLEN  from ALU (combinational)
busy  out  1  state != IDLE
op_count  out  CNT_W  completed operations, wraps

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low. On assertion, immediately and regardless of state:
  - state=IDLE, prio=0, all resp valids=0, resp_data=0, alu_* outputs=0, op_count=0.
  - Any in-flight op is discarded with no response.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- Grant (combinational, IDLE only):
  - Only req0_valid: grant 0. Only req1_valid: grant 1.
  - Both valid: grant = prio.
  - reqN_ready = (state==IDLE) && grant==N. Both readies are never high together; both are 0 outside IDLE.
- Accept (edge with reqN_valid && reqN_ready):
  - Latch funct3/funct7/rs1/rs2 into the alu_* output registers.
  - Latch owner=N; state->EXEC.
- EXEC (exactly 1 cycle):
  - alu_* stable; at the edge, resp_data<=alu_rd.
  - respOWNER_valid<=1; state->RESP.
- RESP:
  - respOWNER_valid and resp_data are held stable until respOWNER_ready is high at an edge.
  - On that edge: valid<=0, op_count<=op_count+1 (mod 2^CNT_W), prio<=~owner, state->IDLE.
  - resp_ready for the non-owner is ignored.
- Latency and throughput:
  - Accept edge to resp_valid high is 2 edges.
  - Minimum 3 cycles per op; a new accept happens no earlier than the first cycle back in IDLE.
- alu_* outputs hold their last operation after completion; they do not clear.
- funct3/funct7 pass through unmodified. Encodings the ALU does not support are still sequenced normally, and whatever alu_rd returns is delivered.
- Requester dropping valid before ready: legal; nothing is latched.
- busy=1 in EXEC and RESP.

Test Plan:
1. After reset: req0 ADD (funct3=000, funct7=0000000), rs1=5, rs2=3.
   -> req0_ready=1 in the same cycle; resp0_valid rises 2 edges after accept with resp_data=8; resp1_valid stays 0; op_count=1.
2. req0 SUB (funct7=0100000) 10-4 and req1 AND 0xFF&0xF0, both valid in the same IDLE cycle after reset.
   -> req0 served first with resp_data=6; req1 served next with resp_data=0xF0.
   -> Repeat both valid: req0 served first again, since prio returned to 0 after req1 completed.
3. req0 op completes, but resp0_ready is held low for 5 cycles while req1_valid=1.
   -> resp0_valid and resp_data stay stable; req1_ready=0; busy=1.
   -> After resp0_ready=1, req1 is accepted in the following IDLE cycle.
4. req1 SRA (funct3=101, funct7=0100000), rs1=all ones, rs2=4.
   -> alu_funct7=0x20 during EXEC; resp1 delivers all ones; resp0_valid=0.
5. rst_n driven low mid-EXEC.
   -> All outputs zero immediately, with no clock edge required; no response is produced.
   -> After release, a req0 OR 0xF0|0x0F returns 0xFF and op_count=1.
6. CNT_W=2, 4 back-to-back completed ops.
   -> op_count sequence 1, 2, 3, 0.
